// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the display driver and the scan-capture receiver.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hA;
  localparam logic [3:0] BCD_ERR   = 4'hF;

  // Callers zero-extend their select vector to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low segment pattern into a BCD digit and an error flag.
// The blank pattern decodes to BCD_BLANK without error; anything unknown gives BCD_ERR.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = BCD_ERR;
    err_o = 1'b1;
    case (seg_n_i)
      SEG_0:     begin bcd_o = 4'd0;      err_o = 1'b0; end
      SEG_1:     begin bcd_o = 4'd1;      err_o = 1'b0; end
      SEG_2:     begin bcd_o = 4'd2;      err_o = 1'b0; end
      SEG_3:     begin bcd_o = 4'd3;      err_o = 1'b0; end
      SEG_4:     begin bcd_o = 4'd4;      err_o = 1'b0; end
      SEG_5:     begin bcd_o = 4'd5;      err_o = 1'b0; end
      SEG_6:     begin bcd_o = 4'd6;      err_o = 1'b0; end
      SEG_7:     begin bcd_o = 4'd7;      err_o = 1'b0; end
      SEG_8:     begin bcd_o = 4'd8;      err_o = 1'b0; end
      SEG_9:     begin bcd_o = 4'd9;      err_o = 1'b0; end
      SEG_BLANK: begin bcd_o = BCD_BLANK; err_o = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed active-low 7-segment bus, filters it for stability and
// recovers one BCD digit per select position, with per-digit refresh timeout.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     dig_sel,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [NDIG-1:0]     valid,
  output logic [NDIG-1:0]     err,
  output logic [NDIG-1:0]     upd
);

  localparam int RW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_COMMIT = RW'(STABLE_CYC - 2);
  localparam logic [RW-1:0] RUN_SAT    = RW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] TMAX       = TW'(TIMEOUT);

  logic [6:0]        seg_s1_q, seg_s2_q, seg_p_q;
  logic [NDIG-1:0]   sel_s1_q, sel_s2_q, sel_p_q;
  logic [RW-1:0]     run_q, run_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic [NDIG-1:0]   upd_q, upd_d;
  logic [TW-1:0]     tcnt_q [NDIG];
  logic [TW-1:0]     tcnt_d [NDIG];

  logic       same;
  logic       commit;
  logic [3:0] dec_bcd;
  logic       dec_err;

  seg7_to_bcd u_dec (
    .seg_n_i (seg_s2_q),
    .bcd_o   (dec_bcd),
    .err_o   (dec_err)
  );

  // run_q counts matching sample pairs, so a run of STABLE_CYC samples has
  // STABLE_CYC-1 matches; commit fires on the edge that reaches that count.
  always_comb begin
    same   = (seg_s2_q == seg_p_q) && (sel_s2_q == sel_p_q) &&
             is_onehot(32'(sel_s2_q));
    commit = same && (run_q == RUN_COMMIT);
    if (!same)                run_d = '0;
    else if (run_q == RUN_SAT) run_d = run_q;
    else                      run_d = run_q + RW'(1);
  end

  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = err_q;
    upd_d   = '0;
    tcnt_d  = tcnt_q;
    for (int i = 0; i < NDIG; i++) begin
      if (commit && sel_s2_q[i]) begin
        bcd_d[4*i +: 4] = dec_bcd;
        err_d[i]        = dec_err;
        valid_d[i]      = 1'b1;
        upd_d[i]        = 1'b1;
        tcnt_d[i]       = '0;
      end else begin
        if (tcnt_q[i] != TMAX) tcnt_d[i] = tcnt_q[i] + TW'(1);
        if (tcnt_d[i] == TMAX) valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= SEG_BLANK;
      seg_s2_q <= SEG_BLANK;
      seg_p_q  <= SEG_BLANK;
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      sel_p_q  <= '0;
      run_q    <= '0;
      bcd_q    <= {NDIG{BCD_BLANK}};
      valid_q  <= '0;
      err_q    <= '0;
      upd_q    <= '0;
      for (int i = 0; i < NDIG; i++) tcnt_q[i] <= '0;
    end else begin
      seg_s1_q <= seg_n;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      sel_s1_q <= dig_sel;
      sel_s2_q <= sel_s1_q;
      sel_p_q  <= sel_s2_q;
      run_q    <= run_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      for (int i = 0; i < NDIG; i++) tcnt_q[i] <= tcnt_d[i];
    end
  end

  assign bcd_out = bcd_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign upd     = upd_q;

endmodule
